// File: rtl/bt_pkg.sv
// ============================================================================
// Package : bt_pkg
// Brief   : Shared types and constants for the HC-05 UART transmitter.
//           BT_UART_PARITY_EN adds the PARITY state to the FSM encoding.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package bt_pkg;

  localparam int BAUD_DIV_115200 = 434;

  localparam logic [7:0] ASCII_HASH = 8'h23;
  localparam logic [7:0] ASCII_DASH = 8'h2D;

`ifdef BT_UART_PARITY_EN
  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`else
  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_DATA  = 3'd2,
    TX_STOP  = 3'd3
  } tx_state_t;
`endif

endpackage

`default_nettype wire

// File: rtl/bt_byte_fifo.sv
// ============================================================================
// Module  : bt_byte_fifo
// Brief   : Single-clock byte FIFO, power-of-two depth, async active-low reset.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module bt_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr,
  input  logic [7:0] din,
  input  logic       rd,
  output logic       full,
  output logic       empty,
  output logic [7:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          w_wr_en;
  logic          w_rd_en;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign dout    = mem_q[rd_ptr_q];
  // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
  assign w_wr_en = wr && !full;
  assign w_rd_en = rd && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + {{AW{1'b0}}, w_wr_en} - {{AW{1'b0}}, w_rd_en};
    if (w_wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (w_rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) mem_q[wr_ptr_q] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/bt_uart_tx.sv
// ============================================================================
// Module  : bt_uart_tx
// Brief   : FIFO-buffered 8N1 UART transmitter for the HC-05 Bluetooth link.
//           Define BT_UART_PARITY_EN for 8E1 framing.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module bt_uart_tx
  import bt_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD_DIV   = BAUD_DIV_115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       msg_wr,
  input  logic [7:0] msg,
  output logic       bt_tx,
  output logic       fifo_full,
  output logic       tx_busy,
  output logic [7:0] drop_cnt
);

  generate
    if (BAUD_DIV < 2 || BAUD_DIV > 65535 || FIFO_DEPTH < 2 || FIFO_DEPTH > 64 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CLK_HZ < BAUD_DIV) begin : g_bad_cfg
      $error("bt_uart_tx: illegal parameter set");
    end
  endgenerate

  tx_state_t   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic [7:0]  drop_q, drop_d;
`ifdef BT_UART_PARITY_EN
  logic        parity_q, parity_d;
`endif

  logic        w_pop;
  logic        w_empty;
  logic [7:0]  w_head;
  logic        w_bit_end;

  bt_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_50M),
    .rst_n (rst_n),
    .wr    (msg_wr),
    .din   (msg),
    .rd    (w_pop),
    .full  (fifo_full),
    .empty (w_empty),
    .dout  (w_head)
  );

  assign w_bit_end = (baud_q == 16'(BAUD_DIV - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
    w_pop   = 1'b0;
`ifdef BT_UART_PARITY_EN
    parity_d = parity_q;
`endif
    if (state_q != TX_IDLE) baud_d = w_bit_end ? 16'd0 : baud_q + 16'd1;

    // tx_d is the line level for the current state; it lands on bt_tx one cycle later.
    case (state_q)
      TX_IDLE: begin
        if (!w_empty) begin
          w_pop   = 1'b1;
          shift_d = w_head;
          bit_d   = 3'd0;
          baud_d  = 16'd0;
          state_d = TX_START;
`ifdef BT_UART_PARITY_EN
          parity_d = even_parity(w_head);
`endif
        end
      end
      TX_START: begin
        tx_d = 1'b0;
        if (w_bit_end) state_d = TX_DATA;
      end
      TX_DATA: begin
        tx_d = shift_q[0];
        if (w_bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
`ifdef BT_UART_PARITY_EN
            state_d = TX_PARITY;
`else
            state_d = TX_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef BT_UART_PARITY_EN
      TX_PARITY: begin
        tx_d = parity_q;
        if (w_bit_end) state_d = TX_STOP;
      end
`endif
      TX_STOP: begin
        if (w_bit_end) state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_q != TX_IDLE) || !w_empty;
    drop_d = drop_q;
    if (msg_wr && fifo_full && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      drop_q  <= 8'd0;
`ifdef BT_UART_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
`ifdef BT_UART_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign bt_tx    = tx_q;
  assign tx_busy  = busy_q;
  assign drop_cnt = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_bt_uart_tx.sv
// ============================================================================
// Module  : tb_bt_uart_tx
// Brief   : Self-checking bench for bt_uart_tx using a line-decoding receiver model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bt_uart_tx;

  localparam int B = 4;
`ifdef BT_UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       msg_wr;
  logic [7:0] msg;
  logic       bt_tx;
  logic       fifo_full;
  logic       tx_busy;
  logic [7:0] drop_cnt;

  int         tests = 0;
  int         fails = 0;
  int         exp_drop = 0;
  logic       rec_en = 1'b0;
  logic       line_q[$];
  logic [7:0] exp_q[$];

  bt_uart_tx #(
    .CLK_HZ     (50_000_000),
    .BAUD_DIV   (B),
    .FIFO_DEPTH (8)
  ) dut (
    .clk_50M   (clk),
    .rst_n     (rst_n),
    .msg_wr    (msg_wr),
    .msg       (msg),
    .bt_tx     (bt_tx),
    .fifo_full (fifo_full),
    .tx_busy   (tx_busy),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rec_en) line_q.push_back(bt_tx);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line level of serial bit idx of the frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef BT_UART_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Drive inputs, let one rising edge sample them, return 1ns after that edge.
  task automatic step(input logic wr, input logic [7:0] b);
    msg_wr = wr;
    msg    = b;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (tx_busy !== 1'b0 && n < 3000) begin
      step(1'b0, 8'h00);
      n++;
    end
    check({tag, "_drain_timeout"}, 32'(n < 3000), 32'd1);
    repeat (4) step(1'b0, 8'h00);
  endtask

  task automatic send_exact(input logic [7:0] b);
    step(1'b1, b);
    step(1'b0, 8'h00);
    check("pre_start_high", 32'(bt_tx), 32'd1);
    step(1'b0, 8'h00);
    for (int c = 0; c < NB * B; c++) begin
      check($sformatf("frame_%02h_bit%0d", b, c / B), 32'(bt_tx), 32'(frame_bit(b, c / B)));
      if (c == NB * B / 2) check("busy_mid_frame", 32'(tx_busy), 32'd1);
      step(1'b0, 8'h00);
    end
    check("line_idle_after", 32'(bt_tx), 32'd1);
    step(1'b0, 8'h00);
    check("busy_after_stop", 32'(tx_busy), 32'd0);
  endtask

  // Receiver model: find start bits and sample each bit at its centre.
  task automatic decode_and_check(input string tag);
    logic [7:0] got[$];
    int         starts[$];
    int         i = 0;
    while (i < line_q.size()) begin
      if (line_q[i] === 1'b0 && i + NB * B <= line_q.size()) begin
        logic [7:0] d;
        for (int k = 0; k < 8; k++) d[k] = line_q[i + (k + 1) * B + B / 2];
`ifdef BT_UART_PARITY_EN
        check({tag, "_parity"}, 32'(line_q[i + 9 * B + B / 2]), 32'(^d));
`endif
        check({tag, "_stop"}, 32'(line_q[i + (NB - 1) * B + B / 2]), 32'd1);
        got.push_back(d);
        starts.push_back(i);
        i += NB * B;
      end else begin
        i++;
      end
    end
    check({tag, "_frames"}, 32'(got.size()), 32'(exp_q.size()));
    for (int k = 0; k < got.size() && k < exp_q.size(); k++)
      check($sformatf("%s_byte%0d", tag, k), 32'(got[k]), 32'(exp_q[k]));
    for (int k = 1; k < starts.size(); k++)
      check($sformatf("%s_gap%0d", tag, k), 32'(starts[k] - starts[k-1]), 32'(NB * B + 1));
  endtask

  task automatic rec_start();
    line_q.delete();
    exp_q.delete();
    rec_en = 1'b1;
  endtask

  initial begin
    logic [7:0] burst[10];
    logic [7:0] b;
    int         n;

    burst = '{8'h46, 8'h49, 8'h4D, 8'h2D, 8'h43, 8'h53, 8'h55, 8'h31, 8'h2D, 8'h23};
    rst_n  = 1'b0;
    msg_wr = 1'b0;
    msg    = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_vec", 32'({bt_tx, tx_busy, fifo_full, drop_cnt}), 32'({1'b1, 1'b0, 1'b0, 8'd0}));
    rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      step(1'b0, 8'h00);
      check("idle_vec", 32'({bt_tx, tx_busy, fifo_full, drop_cnt}), 32'({1'b1, 1'b0, 1'b0, 8'd0}));
    end

    send_exact(8'h46);

    // A frame already in flight leaves exactly 8 slots for the 10-byte burst.
    rec_start();
    b = 8'($urandom);
    exp_q.push_back(b);
    step(1'b1, b);
    for (int j = 0; j < 10; j++) begin
      step(1'b1, burst[j]);
      if (j < 8) exp_q.push_back(burst[j]);
      if (j == 6) check("full_after_7", 32'(fifo_full), 32'd0);
      if (j == 7) check("full_after_8", 32'(fifo_full), 32'd1);
    end
    step(1'b0, 8'h00);
    exp_drop += 2;
    check("drop_after_burst", 32'(drop_cnt), 32'(exp_drop));
    wait_drain("burst");
    rec_en = 1'b0;
    decode_and_check("burst");

    // Write exactly on the pop edge of a full FIFO: rejected, occupancy 8 -> 7.
    rec_start();
    b = 8'($urandom);
    exp_q.push_back(b);
    step(1'b1, b);
    for (int j = 0; j < 8; j++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      step(1'b1, b);
    end
    repeat (NB * B - 7) step(1'b0, 8'h00);
    check("full_before_pop", 32'(fifo_full), 32'd1);
    step(1'b1, 8'hEE);
    exp_drop += 1;
    check("full_after_pop", 32'(fifo_full), 32'd0);
    check("drop_on_pop_edge", 32'(drop_cnt), 32'(exp_drop));
    b = 8'($urandom);
    exp_q.push_back(b);
    step(1'b1, b);
    check("refull_one_slot", 32'(fifo_full), 32'd1);
    step(1'b0, 8'h00);
    check("drop_after_refill", 32'(drop_cnt), 32'(exp_drop));
    wait_drain("fullpop");
    rec_en = 1'b0;
    decode_and_check("fullpop");

    for (int r = 0; r < 3; r++) begin
      rec_start();
      n = $urandom_range(1, 8);
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        step(1'b1, b);
      end
      step(1'b0, 8'h00);
      check($sformatf("rand%0d_drop", r), 32'(drop_cnt), 32'(exp_drop));
      wait_drain($sformatf("rand%0d", r));
      rec_en = 1'b0;
      decode_and_check($sformatf("rand%0d", r));
    end

    for (int c = 0; c < 400; c++) step(1'b1, 8'($urandom));
    step(1'b0, 8'h00);
    check("drop_saturates", 32'(drop_cnt), 32'd255);
    wait_drain("saturate");

    // Reset in the middle of the data bits of 8'h00 with a second byte queued.
    step(1'b1, 8'h00);
    step(1'b1, 8'h55);
    repeat (B + 5) step(1'b0, 8'h00);
    check("in_data_low", 32'(bt_tx), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_vec", 32'({bt_tx, tx_busy, fifo_full, drop_cnt}), 32'({1'b1, 1'b0, 1'b0, 8'd0}));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 60; c++) begin
      step(1'b0, 8'h00);
      check("post_rst_line", 32'({bt_tx, tx_busy}), 32'({1'b1, 1'b0}));
    end

    send_exact(8'h31);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
